// File: rtl/seat_pkg.sv
// Shared constants and types for the seat reservation expiry controller.
package seat_pkg;

  localparam int MIN_PER_DAY = 1440;
  localparam int TIME_W      = 11;
  localparam int DUR_W       = 11;
  localparam int SUM_W       = TIME_W + 1;

  typedef enum logic {
    IDLE = 1'b0,
    SCAN = 1'b1
  } state_t;

endpackage

// File: rtl/hm_to_minutes.sv
// Converts the timer's hour/minute pair into minute-of-day and flags
// out-of-range time values.
module hm_to_minutes
  import seat_pkg::*;
(
  input  logic [4:0]        hour,
  input  logic [5:0]        minute,
  output logic [TIME_W-1:0] minutes,
  output logic              valid
);

  // 31*60+63 still fits in 11 bits, so invalid inputs cannot overflow
  always_comb begin
    minutes = (TIME_W'(hour) * TIME_W'(60)) + TIME_W'(minute);
    valid   = (hour <= 5'd23) && (minute <= 6'd59);
  end

endmodule

// File: rtl/seat_expiry_ctrl.sv
// Seat reservation table with per-minute expiry scan; releases each seat
// whose absolute expiry minute matches the minute latched at scan start.
module seat_expiry_ctrl
  import seat_pkg::*;
#(
  parameter int NUM_SEATS = 32,
  parameter int SEAT_W    = $clog2(NUM_SEATS)
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [4:0]           hour_in,
  input  logic [5:0]           min_in,
  input  logic                 min_tick,
  input  logic                 day_clear,
  input  logic                 req_valid,
  output logic                 req_ready,
  input  logic                 req_cancel,
  input  logic [SEAT_W-1:0]    req_seat,
  input  logic [DUR_W-1:0]     req_dur,
  output logic                 rsp_valid,
  output logic                 rsp_ok,
  output logic                 rel_valid,
  output logic [SEAT_W-1:0]    rel_seat,
  output logic [NUM_SEATS-1:0] occupied,
  output logic                 busy
);

  localparam logic [SEAT_W-1:0] LAST_IDX = SEAT_W'(NUM_SEATS - 1);

  logic [TIME_W-1:0] now_min;
  logic              time_valid;

  hm_to_minutes u_hm_to_minutes (
    .hour    (hour_in),
    .minute  (min_in),
    .minutes (now_min),
    .valid   (time_valid)
  );

  state_t            state_q, state_d;
  logic [SEAT_W-1:0] idx_q, idx_d;
  logic [TIME_W-1:0] now_q, now_d;
  logic              pending_q, pending_d;
  logic              rel_hit;
  logic [TIME_W-1:0] expiry [NUM_SEATS];

  logic              req_fire;
  logic              seat_in_range;
  logic              seat_occ;
  logic              dur_ok;
  logic              req_ok;
  logic [SUM_W-1:0]  exp_sum;
  logic [TIME_W-1:0] exp_new;

  // Request qualification; expiry wraps past midnight using a 12-bit sum
  always_comb begin
    req_fire      = req_valid & req_ready;
    seat_in_range = int'(req_seat) < NUM_SEATS;
    seat_occ      = seat_in_range && occupied[req_seat];
    dur_ok        = (req_dur != '0) && (req_dur < DUR_W'(MIN_PER_DAY));
    exp_sum       = SUM_W'(now_min) + SUM_W'(req_dur);
    if (exp_sum >= SUM_W'(MIN_PER_DAY)) begin
      exp_new = TIME_W'(exp_sum - SUM_W'(MIN_PER_DAY));
    end else begin
      exp_new = TIME_W'(exp_sum);
    end
    if (req_cancel) begin
      req_ok = seat_occ;
    end else begin
      req_ok = seat_in_range && !seat_occ && dur_ok && time_valid;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      idx_q     <= '0;
      now_q     <= '0;
      pending_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      idx_q     <= idx_d;
      now_q     <= now_d;
      pending_q <= pending_d;
    end
  end

  // A tick arriving on the final scan cycle is folded into the rescan decision
  always_comb begin
    state_d   = state_q;
    idx_d     = idx_q;
    now_d     = now_q;
    pending_d = pending_q;
    rel_hit   = 1'b0;
    req_ready = 1'b0;
    busy      = (state_q == SCAN);
    if (day_clear) begin
      state_d   = IDLE;
      idx_d     = '0;
      pending_d = 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          req_ready = 1'b1;
          if (min_tick && time_valid) begin
            state_d = SCAN;
            idx_d   = '0;
            now_d   = now_min;
          end
        end
        SCAN: begin
          rel_hit = occupied[idx_q] && (expiry[idx_q] == now_q);
          if (min_tick) begin
            pending_d = 1'b1;
          end
          if (idx_q == LAST_IDX) begin
            idx_d     = '0;
            pending_d = 1'b0;
            if ((pending_q || min_tick) && time_valid) begin
              now_d = now_min;
            end else begin
              state_d = IDLE;
            end
          end else begin
            idx_d = idx_q + SEAT_W'(1);
          end
        end
        default: begin
          state_d = IDLE;
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rsp_valid <= 1'b0;
      rsp_ok    <= 1'b0;
      rel_valid <= 1'b0;
      rel_seat  <= '0;
      occupied  <= '0;
      for (int i = 0; i < NUM_SEATS; i++) begin
        expiry[i] <= '0;
      end
    end else begin
      rsp_valid <= req_fire;
      rsp_ok    <= req_fire & req_ok;
      rel_valid <= rel_hit;
      if (rel_hit) begin
        rel_seat <= idx_q;
      end
      if (day_clear) begin
        occupied <= '0;
      end else begin
        if (rel_hit) begin
          occupied[idx_q] <= 1'b0;
        end
        if (req_fire && req_ok) begin
          occupied[req_seat] <= ~req_cancel;
          if (!req_cancel) begin
            expiry[req_seat] <= exp_new;
          end
        end
      end
    end
  end

endmodule

// File: tb/tb_seat_expiry_ctrl.sv
// Scoreboard bench for seat_expiry_ctrl: a reservation model predicts every
// response and release (value and cycle) as stimulus is driven.
module tb_seat_expiry_ctrl;

  localparam int NUM_SEATS = 32;
  localparam int SEAT_W    = 5;

  typedef struct {
    int cyc;
    int val;
  } exp_t;

  logic                 clk;
  logic                 rst_n;
  logic [4:0]           hour_in;
  logic [5:0]           min_in;
  logic                 min_tick;
  logic                 day_clear;
  logic                 req_valid;
  logic                 req_ready;
  logic                 req_cancel;
  logic [SEAT_W-1:0]    req_seat;
  logic [10:0]          req_dur;
  logic                 rsp_valid;
  logic                 rsp_ok;
  logic                 rel_valid;
  logic [SEAT_W-1:0]    rel_seat;
  logic [NUM_SEATS-1:0] occupied;
  logic                 busy;

  seat_expiry_ctrl #(.NUM_SEATS(NUM_SEATS), .SEAT_W(SEAT_W)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .hour_in    (hour_in),
    .min_in     (min_in),
    .min_tick   (min_tick),
    .day_clear  (day_clear),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_cancel (req_cancel),
    .req_seat   (req_seat),
    .req_dur    (req_dur),
    .rsp_valid  (rsp_valid),
    .rsp_ok     (rsp_ok),
    .rel_valid  (rel_valid),
    .rel_seat   (rel_seat),
    .occupied   (occupied),
    .busy       (busy)
  );

  int   cyc = 0;
  int   checkCount = 0;
  int   passCount = 0;
  int   curH = 0;
  int   curM = 0;
  bit   mocc [NUM_SEATS];
  int   mexp [NUM_SEATS];
  exp_t rspQ [$];
  exp_t relQ [$];
  exp_t rspE;
  exp_t relE;

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog");
  end

  task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
    checkCount++;
    if (actual === expected) begin
      passCount++;
    end else begin
      $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", tag, actual, expected);
    end
  endtask

  task automatic stepCycle();
    @(posedge clk);
    #1;
  endtask

  task automatic gotoCycle(input int target);
    while (cyc < target) stepCycle();
  endtask

  task automatic setTime(input int h, input int m);
    curH    = h;
    curM    = m;
    hour_in = 5'(h);
    min_in  = 6'(m);
  endtask

  function automatic logic [31:0] modelOcc();
    logic [31:0] v;
    v = '0;
    for (int i = 0; i < NUM_SEATS; i++) v[i] = mocc[i];
    return v;
  endfunction

  // Scan starting in cycle startCyc checks seat i in startCyc+i; release visible one cycle later
  task automatic pushScan(input int startCyc, input int nowv, input int lastIdx);
    exp_t e;
    for (int i = 0; i <= lastIdx; i++) begin
      if (mocc[i] && mexp[i] == nowv) begin
        e.cyc = startCyc + 1 + i;
        e.val = i;
        relQ.push_back(e);
        mocc[i] = 1'b0;
      end
    end
  endtask

  task automatic applyStimulus(input bit cancel, input int seat, input int dur, input bit alsoTick);
    exp_t e;
    bit   ok;
    bit   tv;
    bit   inRange;
    bit   occ;
    int   nowv;
    int   ex;
    nowv       = curH * 60 + curM;
    tv         = (curH <= 23) && (curM <= 59);
    inRange    = seat < NUM_SEATS;
    occ        = inRange ? mocc[seat] : 1'b0;
    req_valid  = 1'b1;
    req_cancel = cancel;
    req_seat   = SEAT_W'(seat);
    req_dur    = 11'(dur);
    if (cancel) begin
      ok = inRange && occ;
      if (ok) mocc[seat] = 1'b0;
    end else begin
      ok = inRange && !occ && dur >= 1 && dur <= 1439 && tv;
      if (ok) begin
        ex = nowv + dur;
        if (ex >= 1440) ex = ex - 1440;
        mocc[seat] = 1'b1;
        mexp[seat] = ex;
      end
    end
    e.cyc = cyc + 1;
    e.val = int'(ok);
    rspQ.push_back(e);
    if (alsoTick) begin
      min_tick = 1'b1;
      if (tv) pushScan(cyc + 1, nowv, NUM_SEATS - 1);
    end
    stepCycle();
    req_valid = 1'b0;
    min_tick  = 1'b0;
  endtask

  task automatic tickMinute(input int h, input int m);
    int t;
    bit v;
    setTime(h, m);
    v        = (h <= 23) && (m <= 59);
    t        = cyc;
    min_tick = 1'b1;
    if (v) pushScan(t + 1, h * 60 + m, NUM_SEATS - 1);
    stepCycle();
    min_tick = 1'b0;
    @(negedge clk);
    checkOutput("busy_scan_start", 32'(busy), 32'(v));
    gotoCycle(t + NUM_SEATS);
    @(negedge clk);
    checkOutput("busy_scan_end", 32'(busy), 32'(v));
    gotoCycle(t + NUM_SEATS + 1);
    @(negedge clk);
    checkOutput("busy_after_scan", 32'(busy), 32'(0));
    stepCycle();
  endtask

  // Outputs are popped against the scoreboard on the falling edge
  always @(negedge clk) begin
    if (rst_n) begin
      if (rsp_valid) begin
        if (rspQ.size() == 0) begin
          checkOutput("rsp_unexpected", 32'(1), 32'(0));
        end else begin
          rspE = rspQ.pop_front();
          checkOutput("rsp_cycle", cyc, rspE.cyc);
          checkOutput("rsp_ok", 32'(rsp_ok), rspE.val);
        end
      end
      if (rel_valid) begin
        if (relQ.size() == 0) begin
          checkOutput("rel_unexpected", 32'(rel_seat), 32'hFFFF);
        end else begin
          relE = relQ.pop_front();
          checkOutput("rel_cycle", cyc, relE.cyc);
          checkOutput("rel_seat", 32'(rel_seat), relE.val);
        end
      end
    end
  end

  initial begin
    int t;
    rst_n      = 1'b0;
    min_tick   = 1'b0;
    day_clear  = 1'b0;
    req_valid  = 1'b0;
    req_cancel = 1'b0;
    req_seat   = '0;
    req_dur    = '0;
    setTime(0, 0);
    for (int i = 0; i < NUM_SEATS; i++) begin
      mocc[i] = 1'b0;
      mexp[i] = 0;
    end

    @(negedge clk);
    checkOutput("rst_rsp_valid", 32'(rsp_valid), 32'(0));
    checkOutput("rst_rsp_ok", 32'(rsp_ok), 32'(0));
    checkOutput("rst_rel_valid", 32'(rel_valid), 32'(0));
    checkOutput("rst_rel_seat", 32'(rel_seat), 32'(0));
    checkOutput("rst_busy", 32'(busy), 32'(0));
    checkOutput("rst_occupied", occupied, 32'(0));
    checkOutput("rst_req_ready", 32'(req_ready), 32'(1));
    day_clear = 1'b1;
    #1;
    checkOutput("rst_req_ready_dayclr", 32'(req_ready), 32'(0));
    day_clear = 1'b0;
    stepCycle();
    rst_n = 1'b1;
    stepCycle();

    $display("[TB] basic reserve and expiry");
    setTime(10, 58);
    applyStimulus(1'b0, 3, 5, 1'b0);
    @(negedge clk);
    checkOutput("occ3_reserved", 32'(occupied[3]), 32'(1));
    stepCycle();
    tickMinute(10, 59);
    tickMinute(11, 0);
    tickMinute(11, 1);
    tickMinute(11, 2);
    tickMinute(11, 3);
    checkOutput("occ3_released", 32'(occupied[3]), 32'(0));

    $display("[TB] midnight wrap");
    setTime(23, 59);
    applyStimulus(1'b0, 0, 3, 1'b0);
    stepCycle();
    tickMinute(0, 1);
    checkOutput("occ0_before_wrap", 32'(occupied[0]), 32'(1));
    tickMinute(0, 2);
    checkOutput("occ0_after_wrap", 32'(occupied[0]), 32'(0));

    $display("[TB] rejected requests");
    setTime(12, 0);
    applyStimulus(1'b0, 5, 10, 1'b0);
    applyStimulus(1'b0, 5, 10, 1'b0);
    applyStimulus(1'b0, 6, 0, 1'b0);
    applyStimulus(1'b0, 6, 1440, 1'b0);
    setTime(24, 0);
    applyStimulus(1'b0, 6, 5, 1'b0);
    setTime(12, 60);
    applyStimulus(1'b0, 6, 5, 1'b0);
    setTime(12, 0);
    applyStimulus(1'b1, 6, 0, 1'b0);
    @(negedge clk);
    checkOutput("occ_after_errors", occupied, modelOcc());
    stepCycle();
    applyStimulus(1'b1, 5, 0, 1'b0);
    @(negedge clk);
    checkOutput("occ_after_cancel", occupied, modelOcc());
    stepCycle();
    tickMinute(24, 0);
    tickMinute(12, 60);

    $display("[TB] shared expiry and pending rescan");
    setTime(14, 0);
    applyStimulus(1'b0, 1, 20, 1'b0);
    applyStimulus(1'b0, 7, 20, 1'b0);
    applyStimulus(1'b0, 31, 20, 1'b0);
    applyStimulus(1'b0, 10, 21, 1'b0);
    stepCycle();
    setTime(14, 20);
    t        = cyc;
    min_tick = 1'b1;
    pushScan(t + 1, 860, NUM_SEATS - 1);
    stepCycle();
    min_tick = 1'b0;
    gotoCycle(t + 5);
    setTime(14, 21);
    min_tick = 1'b1;
    pushScan(t + NUM_SEATS + 1, 861, NUM_SEATS - 1);
    stepCycle();
    min_tick = 1'b0;
    gotoCycle(t + NUM_SEATS);
    @(negedge clk);
    checkOutput("busy_first_scan_end", 32'(busy), 32'(1));
    gotoCycle(t + NUM_SEATS + 1);
    @(negedge clk);
    checkOutput("busy_rescan_start", 32'(busy), 32'(1));
    gotoCycle(t + 2 * NUM_SEATS);
    @(negedge clk);
    checkOutput("busy_rescan_end", 32'(busy), 32'(1));
    gotoCycle(t + 2 * NUM_SEATS + 1);
    @(negedge clk);
    checkOutput("busy_rescan_done", 32'(busy), 32'(0));
    checkOutput("occ_after_rescan", occupied, modelOcc());
    stepCycle();

    $display("[TB] day_clear during scan");
    setTime(15, 0);
    applyStimulus(1'b0, 5, 30, 1'b0);
    applyStimulus(1'b0, 12, 30, 1'b0);
    applyStimulus(1'b0, 20, 30, 1'b0);
    applyStimulus(1'b0, 25, 30, 1'b0);
    stepCycle();
    setTime(15, 30);
    t        = cyc;
    min_tick = 1'b1;
    pushScan(t + 1, 930, 3);
    stepCycle();
    min_tick = 1'b0;
    gotoCycle(t + 5);
    day_clear  = 1'b1;
    req_valid  = 1'b1;
    req_cancel = 1'b0;
    req_seat   = SEAT_W'(9);
    req_dur    = 11'd5;
    @(negedge clk);
    checkOutput("dayclr_req_ready", 32'(req_ready), 32'(0));
    stepCycle();
    @(negedge clk);
    checkOutput("dayclr_occupied", occupied, 32'(0));
    checkOutput("dayclr_busy", 32'(busy), 32'(0));
    checkOutput("dayclr_req_ready_hold", 32'(req_ready), 32'(0));
    stepCycle();
    day_clear = 1'b0;
    req_valid = 1'b0;
    for (int i = 0; i < NUM_SEATS; i++) mocc[i] = 1'b0;
    @(negedge clk);
    checkOutput("dayclr_released_ready", 32'(req_ready), 32'(1));
    gotoCycle(t + NUM_SEATS + 4);
    @(negedge clk);
    checkOutput("dayclr_still_idle", 32'(busy), 32'(0));
    checkOutput("dayclr_occ_stays", occupied, 32'(0));
    stepCycle();

    $display("[TB] request and tick in the same cycle");
    setTime(16, 0);
    t = cyc;
    applyStimulus(1'b0, 2, 1, 1'b1);
    @(negedge clk);
    checkOutput("same_cycle_busy", 32'(busy), 32'(1));
    checkOutput("same_cycle_occ2", 32'(occupied[2]), 32'(1));
    gotoCycle(t + NUM_SEATS + 2);
    @(negedge clk);
    checkOutput("same_cycle_occ2_kept", 32'(occupied[2]), 32'(1));
    stepCycle();
    tickMinute(16, 1);
    checkOutput("occ2_released", 32'(occupied[2]), 32'(0));

    repeat (4) stepCycle();
    checkOutput("rsp_queue_drained", rspQ.size(), 0);
    checkOutput("rel_queue_drained", relQ.size(), 0);
    $display("%0d/%0d checks passed", passCount, checkCount);
    $finish;
  end

endmodule
